// File: rtl/proc_ctrl_pkg.sv
// ============================================================================
// Module   : proc_ctrl_pkg
// Purpose  : Shared opcodes, state encoding, bus selects and instruction
//            field helpers for the 9-bit processor control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_ctrl_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } state_t;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    function automatic logic [2:0] op_of(input logic [8:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] rx_of(input logic [8:0] ir);
        return ir[RX_MSB:RX_LSB];
    endfunction

    function automatic logic [2:0] ry_of(input logic [8:0] ir);
        return ir[RY_MSB:RY_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_ctrl_reg_sel_dec.sv
// ============================================================================
// Module   : reg_sel_dec
// Purpose  : Binary-to-one-hot register write-enable decoder with enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_sel_dec #(
    parameter int SEL_W = 3,
    parameter int N     = 8
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign onehot[i] = en && (sel == SEL_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/proc_ctrl.sv
// ============================================================================
// Module   : proc_ctrl
// Purpose  : Multi-cycle T0..T3 sequencer for the 9-bit processor datapath.
//            Optional halt opcode enabled by defining PROC_CTRL_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int OPC_W  = 3,
    parameter int RSEL_W = 3,
    parameter int NREGS  = 8,
    parameter int SEL_W  = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic [OPC_W+2*RSEL_W-1:0]   instr,
    output logic                        ir_in,
    output logic [NREGS-1:0]            r_in,
    output logic                        a_in,
    output logic                        g_in,
    output logic                        addsub,
    output logic [SEL_W-1:0]            bus_sel,
    output logic                        done,
    output logic                        busy
);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [OPC_W+2*RSEL_W-1:0]   r_ir;
    logic                        w_wr_en;
    logic [2:0]                  w_op;
    logic [RSEL_W-1:0]           w_rx;
    logic [RSEL_W-1:0]           w_ry;

    assign w_op = op_of(r_ir);
    assign w_rx = rx_of(r_ir);
    assign w_ry = ry_of(r_ir);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == T0 && run) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ir_in        = 1'b0;
        w_wr_en      = 1'b0;
        a_in         = 1'b0;
        g_in         = 1'b0;
        addsub       = 1'b0;
        bus_sel      = '0;
        done         = 1'b0;
        busy         = (r_state != T0);

        case (r_state)
            T0: begin
                ir_in = run;
                if (run) begin
                    w_next_state = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        bus_sel      = SEL_W'(w_ry);
                        w_wr_en      = 1'b1;
                        done         = 1'b1;
                        w_next_state = T0;
                    end
                    OP_MVI: begin
                        bus_sel      = SEL_DIN;
                        w_wr_en      = 1'b1;
                        done         = 1'b1;
                        w_next_state = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel      = SEL_W'(w_rx);
                        a_in         = 1'b1;
                        w_next_state = T2;
                    end
                    OP_HALT: begin
                        done         = 1'b1;
`ifdef PROC_CTRL_HALT_EN
                        w_next_state = HALT;
`else
                        w_next_state = T0;
`endif
                    end
                    default: begin
                        done         = 1'b1;
                        w_next_state = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel      = SEL_W'(w_ry);
                g_in         = 1'b1;
                addsub       = w_op[0];
                w_next_state = T3;
            end
            T3: begin
                bus_sel      = SEL_G;
                w_wr_en      = 1'b1;
                done         = 1'b1;
                w_next_state = T0;
            end
`ifdef PROC_CTRL_HALT_EN
            HALT: begin
                w_next_state = HALT;
            end
`endif
            default: begin
                w_next_state = T0;
            end
        endcase

        // An asserted reset silences every strobe so an aborted step never writes.
        if (!resetn) begin
            ir_in   = 1'b0;
            w_wr_en = 1'b0;
            a_in    = 1'b0;
            g_in    = 1'b0;
            addsub  = 1'b0;
            bus_sel = '0;
            done    = 1'b0;
            busy    = 1'b0;
        end
    end

    reg_sel_dec #(
        .SEL_W (RSEL_W),
        .N     (NREGS)
    ) u_reg_sel_dec (
        .en     (w_wr_en),
        .sel    (w_rx),
        .onehot (r_in)
    );

endmodule

`default_nettype wire
